// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the EX stage: one radix-2 step per cycle, 34-cycle turnaround.
// Define MULDIV_DIV_EN to build the divider; without it func3 4-7 complete normally with a zero result.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [4:0]  rd_out_q;

    logic [2:0]  op_q;
    logic [4:0]  rd_lat_q;
    logic [31:0] mb_q;
    logic [63:0] acc_q;
    logic        neg_q;
`ifdef MULDIV_DIV_EN
    logic [32:0] rem_q;
    logic        sa_q;
    logic        div0_q;
`endif

    logic        accept;
    logic        a_signed, b_signed, sa, sb;
    logic [31:0] ma, mbv;
    logic [32:0] sum;
    logic [63:0] mul_acc;
    logic [63:0] acc_d;
    logic [31:0] res_d;
`ifdef MULDIV_DIV_EN
    logic [32:0] rem_sh, rem_nx;
    logic        ge;
    logic [31:0] quo_nx;
`endif

    // Upper half of the two's complement of p, without forming the full 64-bit negation.
    function automatic logic [31:0] mul_hi(input logic [63:0] p, input logic neg);
        mul_hi = neg ? (~p[63:32] + {31'd0, (p[31:0] == 32'd0)}) : p[63:32];
    endfunction

    function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
        fix_sign = neg ? -v : v;
    endfunction

    assign accept   = (state_q == IDLE) && start && !clear;
    assign a_signed = func3[2] ? ~func3[0] : ((func3[1:0] == 2'd1) || (func3[1:0] == 2'd2));
    assign b_signed = func3[2] ? ~func3[0] : (func3[1:0] == 2'd1);
    assign sa       = a_signed & operand_a[31];
    assign sb       = b_signed & operand_b[31];
    assign ma       = sa ? -operand_a : operand_a;
    assign mbv      = sb ? -operand_b : operand_b;

    // Shift-add: the multiplier sits in acc[31:0] and is consumed LSB first.
    assign sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb_q} : 33'd0);
    assign mul_acc = {sum, acc_q[31:1]};

`ifdef MULDIV_DIV_EN
    assign rem_sh = {rem_q[31:0], acc_q[31]};
    assign ge     = rem_sh >= {1'b0, mb_q};
    assign rem_nx = ge ? (rem_sh - {1'b0, mb_q}) : rem_sh;
    assign quo_nx = {acc_q[30:0], ge};
    assign acc_d  = op_q[2] ? {acc_q[63:32], quo_nx} : mul_acc;
`else
    assign acc_d  = mul_acc;
`endif

    always_comb begin
        res_d = '0;
        case (op_q)
            3'd0:             res_d = mul_acc[31:0];
            3'd1, 3'd2, 3'd3: res_d = mul_hi(mul_acc, neg_q);
`ifdef MULDIV_DIV_EN
            3'd4, 3'd5:       res_d = div0_q ? 32'hFFFF_FFFF : fix_sign(quo_nx, neg_q);
            3'd6, 3'd7:       res_d = fix_sign(rem_nx[31:0], sa_q);
`endif
            default:          res_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= res_d;
                        rd_out_q <= rd_lat_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q     <= func3;
            rd_lat_q <= rd_in;
            mb_q     <= mbv;
            acc_q    <= {32'd0, ma};
            neg_q    <= sa ^ sb;
`ifdef MULDIV_DIV_EN
            rem_q    <= '0;
            sa_q     <= sa;
            div0_q   <= (operand_b == 32'd0);
`endif
        end else if (state_q == CALC) begin
            acc_q <= acc_d;
`ifdef MULDIV_DIV_EN
            rem_q <= rem_nx;
`endif
        end
    end

    assign stall  = accept || (state_q == CALC);
    assign busy   = (state_q == CALC) || (state_q == DONE);
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv; divide expectations follow MULDIV_DIV_EN.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec = 0;
    int n_err = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .func3(func3),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
        .stall(stall), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op from just after a rising edge and follow it to retirement.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        int stalls;
        start = 1'b1; func3 = f3; operand_a = a; operand_b = b; rd_in = rd;
        #1;
        stalls = stall ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        if (stall) stalls++;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (stall) stalls++;
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, ".latency"}, lat, 32'd32);
        check({tag, ".result"}, result, exp);
        check({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        check({tag, ".stall_cycles"}, stalls, 32'd33);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] dv(input logic [31:0] v);
        dv = DIV_EN ? v : 32'd0;
    endfunction

    initial begin
        int dones;
        reset = 1'b0; clear = 1'b0; start = 1'b0;
        func3 = '0; operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.done", {31'd0, done}, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.rd_out", {27'd0, rd_out}, 32'd0);
        check("rst.stall_idle", {31'd0, stall}, 32'd0);
        start = 1'b1; #1;
        check("rst.stall_start", {31'd0, stall}, 32'd1);
        start = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 32'hFFFF_FFFF);
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, dv(32'd14));
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd10, dv(32'd2));
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11, dv(32'hFFFF_FFFD));
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, dv(32'hFFFF_FFFF));
        run_op("div_by0", 3'd4, 32'h0000_1234, 32'd0, 5'd13, dv(32'hFFFF_FFFF));
        run_op("rem_by0", 3'd6, 32'h0000_1234, 32'd0, 5'd14, dv(32'h0000_1234));
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, dv(32'h8000_0000));
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, dv(32'd0));

        // Flush a divide 10 cycles in, then issue a multiply right away.
        start = 1'b1; func3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr.done", {31'd0, done}, 32'd0);
        check("clr.busy", {31'd0, busy}, 32'd0);
        check("clr.stall", {31'd0, stall}, 32'd0);
        check("clr.result_kept", result, dv(32'd0));
        check("clr.rd_kept", {27'd0, rd_out}, 32'd16);
        run_op("mul_after_clr", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12);

        // Reset in the middle of a multiply.
        start = 1'b1; func3 = 3'd0; operand_a = 32'd9; operand_b = 32'd9; rd_in = 5'd22;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        check("mrst.done", {31'd0, done}, 32'd0);
        check("mrst.busy", {31'd0, busy}, 32'd0);
        check("mrst.stall", {31'd0, stall}, 32'd0);
        check("mrst.result", result, 32'd0);
        check("mrst.rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk); reset = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("mrst.no_done", dones, 32'd0);
        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd23, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, consuming operands and func3 straight from the ID/EX pipeline register outputs. Runs one radix-2 step per cycle with a fixed 34-cycle turnaround per operation. Holds the front of the pipeline through `stall`, and returns the result with its destination register for the EX/MEM register. Honours the same `clear` (flush) the pipeline registers use for branch mispredicts.

## Interface
Parameters:
- XLEN, 32, operand and result width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; aborts any operation in flight.
- start  in  1  ID/EX holds an M-extension instruction (opbit=1, func7 bit=1).
- func3  in  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  in  32  rs1 value after forwarding.
- operand_b  in  32  rs2 value after forwarding.
- rd_in  in  5  destination register.
- stall  out  1  freeze PC, IF/ID and ID/EX; combinational.
- busy  out  1  an operation is accepted and not yet retired.
- done  out  1  one-cycle pulse; `result`/`rd_out` valid.
- result  out  32  operation result.
- rd_out  out  5  destination register of `result`.

## Operation
- States: IDLE, CALC, DONE. Counter `cnt` is 5 bits.
- IDLE:
  - `start`=1 and `clear`=0 at an edge latches func3, rd_in and operands, clears `cnt`, and goes to CALC.
  - Signed ops store operand magnitudes plus the result sign.
  - MULHSU treats only operand_a as signed.
- CALC:
  - Multiply: one shift-add step per cycle into a 64-bit accumulator.
  - Divide: one restoring step per cycle (33-bit partial remainder).
  - After the `cnt`=31 step the unit goes to DONE.
- DONE:
  - Result is selected and sign-corrected into `result`; `done`=1 for exactly one cycle.
  - Then IDLE. `start` is not sampled in DONE.
- Result selection:
  - MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32] after two's-complement correction.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - The remainder sign follows the dividend.
- Special cases keep the same latency:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = operand_a.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `start` while in CALC or DONE is ignored. The ID/EX contents are frozen by `stall`, so nothing is lost.
- `clear`=1 forces IDLE at the next edge from any state:
  - No `done` pulse for the aborted op.
  - `result` and `rd_out` keep their last values.
  - `clear` takes priority over `start`.
- `busy` = state is CALC or DONE.
- `stall` = (IDLE and `start` and not `clear`) or CALC.
- `stall` drops in DONE so the pipeline advances on the same edge at which the result is taken.

## Timing
- Reset values: state IDLE, `cnt` 0, `done` 0, `busy` 0, `result` 0x00000000, `rd_out` 0. `stall` is combinational and reads 0 unless `start` is high.
- Reset is honoured mid-operation at any cycle; there is no `done` afterwards.
- Start accepted at edge E0: CALC covers edges E1–E32, DONE is entered at E32 (`done` high in the cycle after E32), and the unit is back in IDLE at E33.
- `done`, `result` and `rd_out` are registered outputs.
- A back-to-back M instruction arrives with `start` in the cycle after DONE. Turnaround is 34 cycles per op.

## Configuration
- `MULDIV_DIV_EN` defined: all eight func3 ops are implemented.
- Undefined:
  - The divider datapath is omitted.
  - func3 4–7 still run the full 34-cycle sequence and pulse `done`, with `result` = 0x00000000.
  - Multiply ops are unchanged.

## Test plan
- Reset then MUL 7 × 0xFFFFFFFD → `done` 33 cycles after accept, `result` 0xFFFFFFEB, `rd_out` = rd_in, `stall` high for 33 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIVU 100/7 → 14, REMU → 2. DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD, REM → 0xFFFFFFFF.
- DIV 0x1234/0 → 0xFFFFFFFF, REM → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- `clear` 10 cycles into a DIV → IDLE next edge, no `done`, `stall` low. An immediate new MUL 3×4 → 12 with normal latency. Asserting `reset` mid-MUL → all outputs at reset values.
- Build without `MULDIV_DIV_EN`: DIVU 100/7 → `done` after 33 cycles, `result` 0. MUL 3×4 → 12.
